// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write-bus driver.
// Holds the FSM state encoding, common command bytes and the long-execution test.
// Ports: none (package).
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SETUP      = 3'd1,
        ST_PULSE      = 3'd2,
        ST_HOLD       = 3'd3,
        ST_EXEC       = 3'd4,
        ST_POLL_SETUP = 3'd5,
        ST_POLL_PULSE = 3'd6
    } lcd_state_t;

    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_DDRAM_L1 = 8'h80;
    localparam logic [7:0] CMD_DDRAM_L2 = 8'hC0;

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return (!rs) && (data[7:2] == 6'd0) && (data != 8'h00);
    endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// Saturating down-counter shared by all timed driver states.
// Latency: load takes effect next cycle; done is high while the count is zero.
// Backpressure: none; load has priority over decrement, count never wraps below zero.
// Ports: clk, rst (sync, active-high), load/load_val, en, done.
module lcd_delay_cnt #(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // A state lasting N cycles is loaded with N-1 and leaves on the cycle count hits zero.
    assign done = (cnt == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// Converts one accepted command/data byte into a timed HD44780 write cycle.
// Latency: accept to E rise = T_SETUP+1 cycles; accept to next ready = 1+T_SETUP+T_PULSE+T_HOLD+W.
// Backpressure: req_ready low for the whole transfer; req_valid while busy is ignored.
// Ports: clk, rst (sync, active-high); req_valid/req_ready/req_rs/req_data request side;
//        busy (= ~req_ready); LCD_E, LCD_RS, LCD_RW, LCD_DATA bus outputs, all registered.
// Optional: LCD_BF_POLL_EN adds lcd_bf and replaces the fixed EXEC wait by busy-flag polling.
module lcd_bus_driver
    import lcd_pkg::*;
#(
    parameter int T_SETUP     = 3,
    parameter int T_PULSE     = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 76000,
    parameter int CNT_W       = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rs,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA
`ifdef LCD_BF_POLL_EN
    ,
    input  logic       lcd_bf
`endif
);

    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_EXEC_LONG - 1);

    lcd_state_t       state, state_nxt;
    lcd_state_t       after_setup, after_pulse, after_hold, first_state;
    logic             accept;
    logic             rs_sel;
    logic [7:0]       data_sel;
    logic             long_sel;
    logic             advance;
    logic             dly_load;
    logic [CNT_W-1:0] dly_val;
    logic             dly_done;

    assign accept = (state == ST_IDLE) && req_valid && req_ready;

    // While idle the byte being offered decides the wait; afterwards the captured byte does.
    assign rs_sel   = (state == ST_IDLE) ? req_rs   : LCD_RS;
    assign data_sel = (state == ST_IDLE) ? req_data : LCD_DATA;
    assign long_sel = is_long_cmd(rs_sel, data_sel);

    // Successor chains resolve zero-length phases so no cycle is wasted on them.
`ifdef LCD_BF_POLL_EN
    localparam logic [CNT_W-1:0] LD_POLL_PULSE = CNT_W'((T_PULSE > 0) ? T_PULSE - 1 : 0);

    logic in_poll, in_poll_nxt, poll_start, tmo_done, lcd_rw_q;

    assign after_hold  = (T_SETUP != 0) ? ST_POLL_SETUP : ST_POLL_PULSE;
    assign in_poll     = (state == ST_POLL_SETUP) || (state == ST_POLL_PULSE);
    assign in_poll_nxt = (state_nxt == ST_POLL_SETUP) || (state_nxt == ST_POLL_PULSE);
    assign poll_start  = in_poll_nxt && !in_poll;

    // Overall polling timeout, independent of the per-phase timer.
    lcd_delay_cnt #(.CNT_W(CNT_W)) u_tmo_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (poll_start),
        .load_val (LD_LONG),
        .en       (in_poll),
        .done     (tmo_done)
    );
`else
    logic exec_nonzero;

    assign exec_nonzero = long_sel ? (T_EXEC_LONG != 0) : (T_EXEC != 0);
    assign after_hold   = exec_nonzero ? ST_EXEC : ST_IDLE;
`endif
    assign after_pulse = (T_HOLD  != 0) ? ST_HOLD  : after_hold;
    assign after_setup = (T_PULSE != 0) ? ST_PULSE : after_pulse;
    assign first_state = (T_SETUP != 0) ? ST_SETUP : after_setup;

    always_comb begin
        state_nxt = state;
        advance   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = first_state;
                    advance   = 1'b1;
                end
            end
            ST_SETUP: begin
                if (dly_done) begin
                    state_nxt = after_setup;
                    advance   = 1'b1;
                end
            end
            ST_PULSE: begin
                if (dly_done) begin
                    state_nxt = after_pulse;
                    advance   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (dly_done) begin
                    state_nxt = after_hold;
                    advance   = 1'b1;
                end
            end
            ST_EXEC: begin
                if (dly_done) begin
                    state_nxt = ST_IDLE;
                end
            end
`ifdef LCD_BF_POLL_EN
            ST_POLL_SETUP: begin
                if (tmo_done) begin
                    state_nxt = ST_IDLE;
                end else if (dly_done) begin
                    state_nxt = ST_POLL_PULSE;
                    advance   = 1'b1;
                end
            end
            ST_POLL_PULSE: begin
                if (tmo_done) begin
                    state_nxt = ST_IDLE;
                end else if (dly_done) begin
                    // Busy flag is sampled on the last cycle of the read strobe.
                    state_nxt = lcd_bf ? ((T_SETUP != 0) ? ST_POLL_SETUP : ST_POLL_PULSE)
                                       : ST_IDLE;
                    advance   = lcd_bf;
                end
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Every phase entry (including a poll restarting itself) reloads the phase timer.
    always_comb begin
        dly_load = advance;
        dly_val  = '0;
        case (state_nxt)
            ST_SETUP:      dly_val = LD_SETUP;
            ST_PULSE:      dly_val = LD_PULSE;
            ST_HOLD:       dly_val = LD_HOLD;
            ST_EXEC:       dly_val = long_sel ? LD_LONG : LD_EXEC;
`ifdef LCD_BF_POLL_EN
            ST_POLL_SETUP: dly_val = LD_SETUP;
            ST_POLL_PULSE: dly_val = LD_POLL_PULSE;
`endif
            default:       dly_val = '0;
        endcase
    end

    lcd_delay_cnt #(.CNT_W(CNT_W)) u_dly_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (dly_load),
        .load_val (dly_val),
        .en       (state != ST_IDLE),
        .done     (dly_done)
    );

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            req_ready <= 1'b0;
            LCD_E     <= 1'b0;
            LCD_RS    <= 1'b0;
            LCD_DATA  <= 8'h00;
        end else begin
            state     <= state_nxt;
            req_ready <= (state_nxt == ST_IDLE);
            LCD_E     <= (state_nxt == ST_PULSE) || (state_nxt == ST_POLL_PULSE);
            if (accept) begin
                LCD_RS   <= req_rs;
                LCD_DATA <= req_data;
            end
`ifdef LCD_BF_POLL_EN
            else if (poll_start) begin
                LCD_RS <= 1'b0;
            end
`endif
        end
    end

`ifdef LCD_BF_POLL_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lcd_rw_q <= 1'b0;
        end else if (accept) begin
            lcd_rw_q <= 1'b0;
        end else if (poll_start) begin
            lcd_rw_q <= 1'b1;
        end
    end

    assign LCD_RW = lcd_rw_q;
`else
    assign LCD_RW = 1'b0;
`endif

    assign busy = ~req_ready;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Directed bench for lcd_bus_driver with short timing parameters.
// Checks reset values, E waveform, ready timing, back-to-back handshakes and reset mid-transfer.
// Ports: none (top-level bench).
`timescale 1ns/1ps
module tb_lcd_bus_driver;
    import lcd_pkg::*;

    localparam int TS = 3;
    localparam int TP = 4;
    localparam int TH = 2;
    localparam int TE = 10;
    localparam int TL = 50;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic       req_rs;
    logic [7:0] req_data;
    logic       busy;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic [7:0] LCD_DATA;

    int n_vec = 0;
    int n_bad = 0;
    int rises = 0;

`ifdef LCD_BF_POLL_EN
    logic lcd_bf;
    logic bf_stuck = 1'b0;
    int   bf_high  = 0;
    // rises counts E pulses of the current transfer: 1 is the write, 2.. are polls.
    assign lcd_bf = bf_stuck || (rises <= bf_high + 1);
`endif

    always #5 clk = ~clk;

    lcd_bus_driver #(
        .T_SETUP     (TS),
        .T_PULSE     (TP),
        .T_HOLD      (TH),
        .T_EXEC      (TE),
        .T_EXEC_LONG (TL),
        .CNT_W       (17)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rs    (req_rs),
        .req_data  (req_data),
        .busy      (busy),
        .LCD_E     (LCD_E),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .LCD_DATA  (LCD_DATA)
`ifdef LCD_BF_POLL_EN
        ,
        .lcd_bf    (lcd_bf)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Cycles from the acceptance cycle to the next req_ready=1 cycle.
    function automatic int exp_ready(input int w);
`ifdef LCD_BF_POLL_EN
        return 1 + TS + TP + TH + (TS + TP) + 0 * w;
`else
        return 1 + TS + TP + TH + w;
`endif
    endfunction

    // Entered #1 after an edge with req_ready high; cycle 0 is the acceptance cycle.
    task automatic run_xfer(input string tag, input logic rs, input logic [7:0] d, input int w);
        int   e_first = -1;
        int   e_cnt   = 0;
        int   rdy_at  = -1;
        logic prev_e  = 1'b0;
        req_valid = 1'b1;
        req_rs    = rs;
        req_data  = d;
        rises     = 0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_data  = 8'hFF;
        for (int c = 1; c <= 400; c++) begin
            if (c == 1) begin
                check_val({tag, " rs"},   LCD_RS,   rs);
                check_val({tag, " data"}, LCD_DATA, d);
                check_val({tag, " busy"}, busy,     1);
                check_val({tag, " rw"},   LCD_RW,   0);
            end
            if (LCD_E && !prev_e) rises++;
            if (LCD_E && rises == 1) begin
                if (e_first < 0) e_first = c;
                e_cnt++;
            end
            prev_e = LCD_E;
            if (req_ready) begin
                rdy_at = c;
                break;
            end
            @(posedge clk); #1;
        end
        check_val({tag, " e_rise"},  e_first, TS + 1);
        check_val({tag, " e_width"}, e_cnt,   TP);
        check_val({tag, " ready"},   rdy_at,  exp_ready(w));
    endtask

`ifdef LCD_BF_POLL_EN
    task automatic poll_xfer(input string tag, input int high, input logic stuck,
                             input int exp_rdy, input int exp_rises);
        int   rdy_at = -1;
        logic prev_e = 1'b0;
        bf_high   = high;
        bf_stuck  = stuck;
        rises     = 0;
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h5A;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            if (c == 1 + TS + TP + TH) begin
                check_val({tag, " poll rw"}, LCD_RW, 1);
                check_val({tag, " poll rs"}, LCD_RS, 0);
            end
            if (LCD_E && !prev_e) rises++;
            prev_e = LCD_E;
            if (req_ready) begin
                rdy_at = c;
                break;
            end
            @(posedge clk); #1;
        end
        check_val({tag, " ready"},  rdy_at, exp_rdy);
        check_val({tag, " pulses"}, rises,  exp_rises);
        bf_high  = 0;
        bf_stuck = 1'b0;
    endtask
`endif

    initial begin
        int   bad;
        int   rdy_at;
        logic got_rdy;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_rs    = 1'b0;
        req_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst e",     LCD_E,     0);
        check_val("rst rs",    LCD_RS,    0);
        check_val("rst rw",    LCD_RW,    0);
        check_val("rst data",  LCD_DATA,  0);
        check_val("rst ready", req_ready, 0);

        rst = 1'b0;
        @(posedge clk); #1;
        check_val("post-rst ready", req_ready, 1);
        check_val("post-rst busy",  busy,      0);
        repeat (3) @(posedge clk);
        #1;
        check_val("idle e",     LCD_E,     0);
        check_val("idle ready", req_ready, 1);

        run_xfer("char H",   1'b1, 8'h48,        TE);
        run_xfer("clear",    1'b0, CMD_CLEAR,    TL);
        run_xfer("func set", 1'b0, CMD_FUNC_SET, TE);
        run_xfer("home",     1'b0, CMD_HOME,     TL);
        run_xfer("home3",    1'b0, 8'h03,        TL);
        run_xfer("cmd04",    1'b0, 8'h04,        TE);
        run_xfer("data01",   1'b1, 8'h01,        TE);
        run_xfer("cmd00",    1'b0, 8'h00,        TE);
        run_xfer("ddram l2", 1'b0, CMD_DDRAM_L2, TE);

        // Valid held with changing data while busy; next byte taken on the ready cycle.
        bad       = 0;
        rdy_at    = -1;
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h41;
        @(posedge clk); #1;
        for (int c = 1; c <= 400; c++) begin
            if (LCD_DATA !== 8'h41) bad++;
            if (req_ready) begin
                rdy_at = c;
                break;
            end
            req_data = 8'h50 + 8'(c);
            @(posedge clk); #1;
        end
        req_data = 8'h42;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_val("b2b hold data", bad,       0);
        check_val("b2b ready",     rdy_at,    exp_ready(TE));
        check_val("b2b next data", LCD_DATA,  8'h42);
        check_val("b2b next busy", req_ready, 0);
        got_rdy = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (req_ready) begin
                got_rdy = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check_val("b2b drain", got_rdy, 1);

        // Reset while E is high abandons the transfer at once.
        req_valid = 1'b1;
        req_rs    = 1'b1;
        req_data  = 8'h33;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (TS + 1) @(posedge clk);
        #1;
        check_val("pre-rst e", LCD_E, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("mid-rst e",     LCD_E,     0);
        check_val("mid-rst ready", req_ready, 0);
        check_val("mid-rst data",  LCD_DATA,  0);
        check_val("mid-rst rs",    LCD_RS,    0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("after mid-rst ready", req_ready, 1);
        run_xfer("after rst", 1'b0, CMD_DISP_ON, TE);

`ifdef LCD_BF_POLL_EN
        // Busy for 3 polls then clear: 4 polls of TS+TP cycles each.
        poll_xfer("bf3", 3, 1'b0, 1 + TS + TP + TH + 4 * (TS + TP), 5);
        // Stuck busy: timeout after TL poll cycles; 7 full polls fit before it.
        poll_xfer("bf stuck", 0, 1'b1, 1 + TS + TP + TH + TL, 8);
        run_xfer("after poll", 1'b0, CMD_ENTRY, TE);
`endif

        check_val("final e", LCD_E, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
